if_prefetch: RTL and testbench

IF_PREFETCH -- requirements
Module: if_prefetch

---
 rtl/if_prefetch_if.sv | 50 +++++
 rtl/if_prefetch.sv | 162 ++++++++++++++++
 tb/tb_if_prefetch.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_prefetch_if.sv
// -----------------------------------------------------------------------------
// if_prefetch_if
//   Bundles the three handshakes around the instruction-fetch prefetch unit:
//   the redirect request from EX, the instruction-memory request/response
//   channel, and the fetch-to-decode (IF/ID) channel.
//
//   master modport : the prefetch unit itself
//     in  branch_taken, branch_target        redirect from EX
//     out imem_req_valid, imem_addr          fetch request
//     in  imem_req_ready                     memory accepts request
//     in  imem_rsp_valid, imem_rsp_data      in-order memory response
//     out if_id_valid, if_id_pc_out,         queue head towards ID
//         if_id_pc_4_out, if_id_instr_out
//     in  if_id_ready                        ID consumes head (0 = stall)
//   slave modport  : the environment (EX, memory, ID), directions reversed
// -----------------------------------------------------------------------------
interface if_prefetch_if #(
    parameter int unsigned XLEN = 32
);
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;

    logic            if_id_valid;
    logic            if_id_ready;
    logic [XLEN-1:0] if_id_pc_out;
    logic [XLEN-1:0] if_id_pc_4_out;
    logic [31:0]     if_id_instr_out;

    modport master (
        input  branch_taken, branch_target,
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output if_id_valid, if_id_pc_out, if_id_pc_4_out, if_id_instr_out,
        input  if_id_ready
    );

    modport slave (
        output branch_taken, branch_target,
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  if_id_valid, if_id_pc_out, if_id_pc_4_out, if_id_instr_out,
        output if_id_ready
    );
endinterface

// File: rtl/if_prefetch.sv
// -----------------------------------------------------------------------------
// if_prefetch
//   Instruction-fetch prefetch queue. Issues sequential fetches from fetch_pc
//   to an in-order instruction memory, buffers returned words with their PCs
//   in a DEPTH-entry FIFO, and presents the head to ID with a valid/ready
//   handshake. A redirect from EX empties the queue and restarts fetching at
//   the word-aligned target; responses still in flight at that moment are
//   counted as stale and discarded when they return.
//
//   Ports
//     clk  : sole clock, rising edge
//     rst  : synchronous, active-high; wins over redirect and all handshakes
//     bus  : if_prefetch_if.master (redirect, imem request/response, IF/ID)
//
//   Parameters
//     XLEN     : PC/address width (32 or 64)
//     DEPTH    : queue entries, power of 2 in 2..16
//     RESET_PC : first fetch address after reset
// -----------------------------------------------------------------------------
module if_prefetch #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    if_prefetch_if.master bus
);
    localparam int unsigned     PTR_W   = $clog2(DEPTH);
    localparam int unsigned     CNT_W   = PTR_W + 1;
    // count + live + stale never exceeds DEPTH, two extra bits keep the sum safe.
    localparam int unsigned     SUM_W   = CNT_W + 2;
    localparam logic [31:0]     NOP     = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    // Queue storage
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];

    // State
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;   // next address to request
    logic [XLEN-1:0] tail_pc_q,  tail_pc_d;    // PC of the oldest live request
    logic [XLEN-1:0] last_pc_q,  last_pc_d;    // last head PC shown to ID
    logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [CNT_W-1:0] count_q,   count_d;      // queued entries
    logic [CNT_W-1:0] live_q,    live_d;       // in flight, will be kept
    logic [CNT_W-1:0] stale_q,   stale_d;      // in flight, will be dropped

    // Handshake decode
    logic [SUM_W-1:0] credit_used;
    logic             req_valid;
    logic             req_fire;
    logic             rsp_push;
    logic             rsp_drop;
    logic             head_valid;
    logic             pop;
    logic [XLEN-1:0]  head_pc;
    logic [XLEN-1:0]  pc_sel;
    logic [XLEN-1:0]  target_aligned;

    always_comb begin
        credit_used    = SUM_W'(count_q) + SUM_W'(live_q) + SUM_W'(stale_q);
        // Every outstanding request owns a queue slot, so a response can
        // always be pushed without checking for room.
        req_valid      = !rst && !bus.branch_taken && (credit_used < SUM_W'(DEPTH));
        req_fire       = req_valid && bus.imem_req_ready;
        rsp_drop       = !rst && bus.imem_rsp_valid && (stale_q != '0);
        rsp_push       = !rst && bus.imem_rsp_valid && (stale_q == '0) && !bus.branch_taken;
        head_valid     = !rst && (count_q != '0) && !bus.branch_taken;
        pop            = head_valid && bus.if_id_ready;
        head_pc        = pc_mem[rd_ptr_q];
        target_aligned = bus.branch_target & ~XLEN'(3);
    end

    // Next-state logic
    // NOTE: every variable gets its hold value first so no path through the
    // block leaves one unassigned, which would infer a latch.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        tail_pc_d  = tail_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        live_d     = live_q;
        stale_d    = stale_q;
        last_pc_d  = head_valid ? head_pc : last_pc_q;

        if (bus.branch_taken) begin
            // Everything in flight becomes stale; a response returning in this
            // very cycle is discarded and retires one of those requests.
            fetch_pc_d = target_aligned;
            tail_pc_d  = target_aligned;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            live_d     = '0;
            stale_d    = stale_q + live_q - CNT_W'(bus.imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (rsp_push) begin
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
                tail_pc_d = tail_pc_q + PC_STEP;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (rsp_drop) begin
                stale_d = stale_q - CNT_W'(1);
            end
            count_d = count_q + CNT_W'(rsp_push) - CNT_W'(pop);
            live_d  = live_q + CNT_W'(req_fire) - CNT_W'(rsp_push);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            tail_pc_q  <= RESET_PC;
            last_pc_q  <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            live_q     <= '0;
            stale_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            tail_pc_q  <= tail_pc_d;
            last_pc_q  <= last_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            live_q     <= live_d;
            stale_q    <= stale_d;
        end
    end

    // NOTE: the queue storage is deliberately not reset; an entry is only
    // read while count_q covers it, so its power-up contents never matter.
    always_ff @(posedge clk) begin
        if (rsp_push) begin
            pc_mem[wr_ptr_q]    <= tail_pc_q;
            instr_mem[wr_ptr_q] <= bus.imem_rsp_data;
        end
    end

    // Outputs
    // With no valid head the PC outputs keep showing the last head.
    assign pc_sel              = rst ? '0 : (head_valid ? head_pc : last_pc_q);

    assign bus.imem_req_valid  = req_valid;
    assign bus.imem_addr       = fetch_pc_q;
    assign bus.if_id_valid     = head_valid;
    assign bus.if_id_pc_out    = pc_sel;
    assign bus.if_id_pc_4_out  = rst ? '0 : pc_sel + PC_STEP;
    assign bus.if_id_instr_out = head_valid ? instr_mem[rd_ptr_q] : NOP;

endmodule

// File: tb/tb_if_prefetch.sv
// -----------------------------------------------------------------------------
// tb_if_prefetch
//   Self-checking bench for if_prefetch (XLEN=32, DEPTH=4, RESET_PC=0).
//   An in-order memory model with programmable latency answers fetches with a
//   PC-derived instruction word. Each test pushes the PCs ID should receive
//   onto a scoreboard queue; every IF/ID handshake pops one entry and compares
//   PC, PC+4 and instruction. Tests add their own inline checks.
// -----------------------------------------------------------------------------
module tb_if_prefetch;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_prefetch_if #(.XLEN(XLEN)) bus ();

    if_prefetch #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected PCs in the order ID must see them.
    logic [31:0] exp_q [$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[29:0], 2'b11} ^ 32'h5A00_0000;
    endfunction

    // ---------------- instruction memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq [$];
    int          mem_lat  = 1;
    bit          mem_rand = 1'b0;
    int          acc_cnt  = 0;
    logic        m_rsp_valid = 1'b0;
    logic        m_req_ready = 1'b0;
    logic [31:0] m_rsp_data  = '0;

    assign bus.imem_rsp_valid = m_rsp_valid;
    assign bus.imem_rsp_data  = m_rsp_data;
    assign bus.imem_req_ready = m_req_ready;

    // Runs mid-cycle: decides this cycle's response and ready, and records a
    // request that the coming rising edge will accept.
    always @(negedge clk) begin
        m_rsp_valid = 1'b0;
        m_rsp_data  = '0;
        if (rst) begin
            mq.delete();
            m_req_ready = 1'b0;
        end else begin
            if (mq.size() != 0 && mq[0].due <= cyc) begin
                m_rsp_valid = 1'b1;
                m_rsp_data  = instr_of(mq[0].addr);
                void'(mq.pop_front());
            end
            m_req_ready = mem_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.imem_req_valid === 1'b1 && m_req_ready) begin
                mq.push_back('{addr: bus.imem_addr, due: cyc + mem_lat});
                acc_cnt++;
            end
        end
    end

    // ---------------- cycle helpers ----------------
    // Move to mid-cycle and let the scoreboard look at the IF/ID handshake.
    task automatic to_neg();
        logic [31:0] e;
        @(negedge clk);
        if (bus.if_id_valid === 1'b1 && bus.if_id_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_pop: got pc=%h, expected no handshake", bus.if_id_pc_out);
            end else begin
                e = exp_q.pop_front();
                if (bus.if_id_pc_out !== e || bus.if_id_pc_4_out !== 32'(e + 32'd4) ||
                    bus.if_id_instr_out !== instr_of(e)) begin
                    errors++;
                    $display("FAIL sb_head: got pc=%h pc4=%h instr=%h, expected pc=%h pc4=%h instr=%h",
                             bus.if_id_pc_out, bus.if_id_pc_4_out, bus.if_id_instr_out,
                             e, 32'(e + 32'd4), instr_of(e));
                end
            end
        end
    endtask

    // Move just past the next rising edge, where inputs are driven.
    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            to_neg();
            to_pos();
        end
    endtask

    task automatic do_reset(input int lat, input bit rnd);
        mem_lat              = lat;
        mem_rand             = rnd;
        bus.branch_taken     = 1'b0;
        bus.branch_target    = '0;
        bus.if_id_ready      = 1'b0;
        exp_q.delete();
        rst = 1'b1;
        run_cycles(2);
        rst = 1'b0;
    endtask

    // Let ID consume until the scoreboard is empty, then stall ID again.
    task automatic drain(input bit rnd, input string name);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            bus.if_id_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            to_neg();
            to_pos();
            if (exp_q.size() == 0) done = 1'b1;
        end
        bus.if_id_ready = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain: %0d entries left, expected 0", name, exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst                  = 1'b1;
        bus.branch_taken     = 1'b0;
        bus.branch_target    = '0;
        bus.if_id_ready      = 1'b0;
        to_neg();
        checks += 5;
        if (bus.if_id_valid !== 1'b0)     begin errors++; $display("FAIL rst_valid: got %b, expected 0", bus.if_id_valid); end
        if (bus.if_id_instr_out !== NOP)  begin errors++; $display("FAIL rst_instr: got %h, expected %h", bus.if_id_instr_out, NOP); end
        if (bus.if_id_pc_out !== 32'h0)   begin errors++; $display("FAIL rst_pc: got %h, expected 0", bus.if_id_pc_out); end
        if (bus.if_id_pc_4_out !== 32'h0) begin errors++; $display("FAIL rst_pc4: got %h, expected 0", bus.if_id_pc_4_out); end
        if (bus.imem_req_valid !== 1'b0)  begin errors++; $display("FAIL rst_req: got %b, expected 0", bus.imem_req_valid); end
        to_pos();
        rst = 1'b0;
        to_neg();
        checks += 2;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL rst_first_req: got valid=%b addr=%h, expected valid=1 addr=0", bus.imem_req_valid, bus.imem_addr);
        end
        if (bus.if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_first_valid: got %b, expected 0", bus.if_id_valid); end
        to_pos();
    endtask

    task automatic test_streaming();
        int t0;
        bit found = 1'b0;
        do_reset(1, 1'b0);
        t0 = cyc;
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        bus.if_id_ready = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            to_neg();
            if (bus.if_id_valid === 1'b1) found = 1'b1;
            else to_pos();
        end
        checks += 2;
        if (!found) begin errors++; $display("FAIL stream_timeout: no valid head, expected one"); end
        // First request goes out in the release cycle; latency 1 + 1.
        if (cyc - t0 != 2) begin errors++; $display("FAIL stream_latency: got %0d cycles, expected 2", cyc - t0); end
        for (int i = 1; i < 4; i++) begin
            to_pos();
            to_neg();
            checks++;
            if (bus.if_id_valid !== 1'b1) begin errors++; $display("FAIL stream_consecutive_%0d: got valid=%b, expected 1", i, bus.if_id_valid); end
        end
        to_pos();
        bus.if_id_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL stream_left: %0d entries left, expected 0", exp_q.size()); end
    endtask

    task automatic test_stall();
        int a0;
        do_reset(1, 1'b0);
        a0 = acc_cnt;
        for (int i = 0; i < 10; i++) begin
            to_neg();
            if (bus.if_id_valid === 1'b1) begin
                checks++;
                if (bus.if_id_pc_out !== 32'h0) begin errors++; $display("FAIL stall_head_%0d: got pc=%h, expected 0", i, bus.if_id_pc_out); end
            end
            to_pos();
        end
        to_neg();
        checks += 3;
        if (acc_cnt - a0 != DEPTH) begin errors++; $display("FAIL stall_requests: got %0d, expected %0d", acc_cnt - a0, DEPTH); end
        if (bus.if_id_valid !== 1'b1 || bus.if_id_pc_out !== 32'h0) begin
            errors++;
            $display("FAIL stall_hold: got valid=%b pc=%h, expected valid=1 pc=0", bus.if_id_valid, bus.if_id_pc_out);
        end
        if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_credit: got req_valid=%b, expected 0", bus.imem_req_valid); end
        to_pos();
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        drain(1'b0, "stall");
    endtask

    task automatic test_flush_stale();
        int a0;
        int nb;
        bit found = 1'b0;
        do_reset(3, 1'b0);
        a0 = acc_cnt;
        bus.if_id_ready = 1'b1;
        exp_q = '{32'h100, 32'h104, 32'h108};
        for (int i = 0; i < 20 && (acc_cnt - a0) < 3; i++) run_cycles(1);
        // Three requests in flight; the first answer arrives in this cycle.
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h100;
        nb = cyc;
        to_neg();
        checks += 3;
        if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL flush_req: got %b, expected 0", bus.imem_req_valid); end
        if (bus.if_id_valid !== 1'b0)    begin errors++; $display("FAIL flush_valid: got %b, expected 0", bus.if_id_valid); end
        if (bus.if_id_instr_out !== NOP) begin errors++; $display("FAIL flush_nop: got %h, expected %h", bus.if_id_instr_out, NOP); end
        to_pos();
        bus.branch_taken = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            to_neg();
            if (bus.if_id_valid === 1'b1) found = 1'b1;
            else to_pos();
        end
        checks++;
        // Request in N+1, answer 3 cycles later, visible the cycle after.
        if (!found || cyc - nb != 5) begin
            errors++;
            $display("FAIL flush_latency: got found=%b cycles=%0d, expected found=1 cycles=5", found, cyc - nb);
        end
        to_pos();
        drain(1'b0, "flush");
    endtask

    task automatic test_misaligned();
        do_reset(1, 1'b0);
        run_cycles(8);
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h103;
        to_neg();
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL misal_req_n: got %b, expected 0", bus.imem_req_valid); end
        to_pos();
        bus.branch_taken = 1'b0;
        to_neg();
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL misal_addr: got valid=%b addr=%h, expected valid=1 addr=00000100", bus.imem_req_valid, bus.imem_addr);
        end
        to_pos();
        exp_q = '{32'h100, 32'h104};
        drain(1'b0, "misal");
    endtask

    task automatic test_wrap();
        do_reset(1, 1'b0);
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'hFFFF_FFFC;
        run_cycles(1);
        bus.branch_taken = 1'b0;
        to_neg();
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_addr0: got valid=%b addr=%h, expected valid=1 addr=fffffffc", bus.imem_req_valid, bus.imem_addr);
        end
        to_pos();
        to_neg();
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr1: got valid=%b addr=%h, expected valid=1 addr=0", bus.imem_req_valid, bus.imem_addr);
        end
        to_pos();
        exp_q = '{32'hFFFF_FFFC, 32'h0, 32'h4};
        drain(1'b0, "wrap");
    endtask

    task automatic test_back_to_back();
        do_reset(1, 1'b0);
        exp_q = '{32'h0, 32'h4};
        drain(1'b0, "b2b_pre");
        run_cycles(3);
        to_neg();
        checks++;
        if (bus.if_id_valid !== 1'b1 || bus.if_id_pc_out !== 32'h8) begin
            errors++;
            $display("FAIL b2b_head: got valid=%b pc=%h, expected valid=1 pc=8", bus.if_id_valid, bus.if_id_pc_out);
        end
        to_pos();
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h200;
        to_neg();
        checks += 4;
        if (bus.if_id_valid !== 1'b0)    begin errors++; $display("FAIL b2b_valid: got %b, expected 0", bus.if_id_valid); end
        if (bus.if_id_pc_out !== 32'h8 || bus.if_id_pc_4_out !== 32'hC) begin
            errors++;
            $display("FAIL b2b_pc_hold: got pc=%h pc4=%h, expected pc=8 pc4=c", bus.if_id_pc_out, bus.if_id_pc_4_out);
        end
        if (bus.if_id_instr_out !== NOP) begin errors++; $display("FAIL b2b_nop: got %h, expected %h", bus.if_id_instr_out, NOP); end
        if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL b2b_req0: got %b, expected 0", bus.imem_req_valid); end
        to_pos();
        bus.branch_target = 32'h300;
        to_neg();
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL b2b_req1: got %b, expected 0", bus.imem_req_valid); end
        to_pos();
        bus.branch_taken = 1'b0;
        to_neg();
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h300) begin
            errors++;
            $display("FAIL b2b_addr: got valid=%b addr=%h, expected valid=1 addr=00000300", bus.imem_req_valid, bus.imem_addr);
        end
        to_pos();
        exp_q = '{32'h300, 32'h304};
        drain(1'b0, "b2b");
    endtask

    task automatic test_reset_mid();
        do_reset(1, 1'b0);
        run_cycles(8);
        to_neg();
        checks++;
        if (bus.if_id_valid !== 1'b1) begin errors++; $display("FAIL rmid_full: got valid=%b, expected 1", bus.if_id_valid); end
        to_pos();
        rst = 1'b1;
        to_neg();
        checks += 3;
        if (bus.if_id_valid !== 1'b0 || bus.if_id_instr_out !== NOP) begin
            errors++;
            $display("FAIL rmid_out: got valid=%b instr=%h, expected valid=0 instr=%h", bus.if_id_valid, bus.if_id_instr_out, NOP);
        end
        if (bus.if_id_pc_out !== 32'h0)  begin errors++; $display("FAIL rmid_pc: got %h, expected 0", bus.if_id_pc_out); end
        if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rmid_req: got %b, expected 0", bus.imem_req_valid); end
        to_pos();
        rst = 1'b0;
        to_neg();
        checks += 2;
        if (bus.if_id_valid !== 1'b0) begin errors++; $display("FAIL rmid_empty: got valid=%b, expected 0", bus.if_id_valid); end
        if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL rmid_first_req: got valid=%b addr=%h, expected valid=1 addr=0", bus.imem_req_valid, bus.imem_addr);
        end
        to_pos();
        exp_q = '{32'h0, 32'h4};
        drain(1'b0, "rmid");
    endtask

    task automatic test_backpressure();
        do_reset(2, 1'b1);
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h1000;
        run_cycles(1);
        bus.branch_taken = 1'b0;
        for (int i = 0; i < 16; i++) exp_q.push_back(32'h1000 + 32'(4 * i));
        drain(1'b1, "bp");
    endtask

    initial begin
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.if_id_ready   = 1'b0;
        test_reset();
        test_streaming();
        test_stall();
        test_flush_stale();
        test_misaligned();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_backpressure();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
